// File: rtl/kyber_ct_sink.sv
// Ciphertext sink for the Kyber client core: requests ciphertext words into a
// first-word-fall-through FIFO for the host stream, then captures the shared secret.
module kyber_ct_sink #(
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   k,
  input  logic         start,
  input  logic         ready_c,
  output logic         req_c,
  input  logic         c_valid,
  input  logic [31:0]  c_din,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic         m_last,
  output logic [255:0] ss,
  output logic         ss_valid,
  output logic         done,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int XW = AW + 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [XW-1:0] DEPTH_X  = XW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CT,
    S_SS,
    S_DONE_WAIT,
    S_DONE
  } state_t;

  function automatic logic [8:0] ct_words_for(input logic [2:0] lvl);
    case (lvl)
      3'd2:    return 9'd192;
      3'd3:    return 9'd272;
      default: return 9'd392;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [8:0]      ct_words_q, ct_words_d;
  logic [8:0]      rx_cnt_q, rx_cnt_d;
  logic [2:0]      ss_cnt_q, ss_cnt_d;
  logic [255:0]    ss_q, ss_d;
  logic            ss_valid_q, ss_valid_d;
  logic            overflow_q, overflow_d;
  logic            req_d1_q, req_d2_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [32:0]     mem_q [DEPTH];

  logic            push, push_last, pop, fifo_full;
  logic [1:0]      inflight;
  logic [9:0]      rx_plus;
  logic [XW-1:0]   fifo_plus;
  logic [32:0]     head;

  // Requests issued in the last two cycles may still return a word, so they
  // reserve both ciphertext budget and FIFO space until their slot has passed.
  assign inflight  = {1'b0, req_d1_q} + {1'b0, req_d2_q};
  assign rx_plus   = {1'b0, rx_cnt_q} + {8'd0, inflight};
  assign fifo_plus = {1'b0, fifo_cnt_q} + XW'(inflight);

  assign req_c = (state_q == S_CT) && ready_c &&
                 (rx_plus < {1'b0, ct_words_q}) && (fifo_plus < DEPTH_X);

  assign fifo_full = (fifo_cnt_q == FULL_CNT);
  assign m_valid   = (fifo_cnt_q != '0);
  assign pop       = m_valid & m_ready;
  assign head      = mem_q[rd_ptr_q];
  assign m_data    = m_valid ? head[31:0] : 32'd0;
  assign m_last    = m_valid & head[32];

  assign ss        = ss_q;
  assign ss_valid  = ss_valid_q;
  assign overflow  = overflow_q;
  assign done      = (state_q == S_DONE);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d    = state_q;
    ct_words_d = ct_words_q;
    rx_cnt_d   = rx_cnt_q;
    ss_cnt_d   = ss_cnt_q;
    ss_d       = ss_q;
    ss_valid_d = ss_valid_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    push_last  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_CT;
          ct_words_d = ct_words_for(k);
          rx_cnt_d   = '0;
          ss_cnt_d   = '0;
          ss_d       = '0;
          ss_valid_d = 1'b0;
          overflow_d = 1'b0;
        end
        if (c_valid) overflow_d = 1'b1;
      end
      S_CT: begin
        if (c_valid) begin
          if (fifo_full && !pop) begin
            overflow_d = 1'b1;
          end else begin
            push     = 1'b1;
            rx_cnt_d = rx_cnt_q + 9'd1;
            if (rx_cnt_q + 9'd1 == ct_words_q) begin
              push_last = 1'b1;
              state_d   = S_SS;
            end
          end
        end
      end
      S_SS: begin
        if (c_valid) begin
          ss_d     = {c_din, ss_q[255:32]};
          ss_cnt_d = ss_cnt_q + 3'd1;
          if (ss_cnt_q == 3'd7) begin
            ss_valid_d = 1'b1;
            state_d    = S_DONE_WAIT;
          end
        end
      end
      S_DONE_WAIT: begin
        if (c_valid) overflow_d = 1'b1;
        if (fifo_cnt_q == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ct_words_q <= '0;
      rx_cnt_q   <= '0;
      ss_cnt_q   <= '0;
      ss_q       <= '0;
      ss_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      req_d1_q   <= 1'b0;
      req_d2_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ct_words_q <= ct_words_d;
      rx_cnt_q   <= rx_cnt_d;
      ss_cnt_q   <= ss_cnt_d;
      ss_q       <= ss_d;
      ss_valid_q <= ss_valid_d;
      overflow_q <= overflow_d;
      req_d1_q   <= req_c;
      req_d2_q   <= req_d1_q;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_last, c_din};
  end

endmodule

// File: tb/tb_kyber_ct_sink.sv
// Randomized bench for kyber_ct_sink: a cycle-level core model drives the
// ciphertext port while a queue-based model predicts every host-side output.
module tb_kyber_ct_sink;

  localparam int DEPTH = 16;
  localparam logic [255:0] SS_LIT =
    256'hA5A50007_A5A50006_A5A50005_A5A50004_A5A50003_A5A50002_A5A50001_A5A50000;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   k;
  logic         start, ready_c, c_valid, m_ready;
  logic [31:0]  c_din;
  logic         req_c, m_valid, m_last, ss_valid, done, overflow;
  logic [31:0]  m_data;
  logic [255:0] ss;

  kyber_ct_sink #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .k(k), .start(start), .ready_c(ready_c),
    .req_c(req_c), .c_valid(c_valid), .c_din(c_din), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .ss(ss),
    .ss_valid(ss_valid), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
  } word_t;

  word_t        exp_q[$];
  int           n_vec = 0, n_err = 0;
  int           ct_rx, ss_rx, ctw, core_ct_sent, core_ss_sent, req_seen, req_total;
  int           dut_pops, last_idx, mr_mode;
  bit           armed, done_m, ovf_m, h1, h2, pipe1, pipe2;
  bit           rdy_rand, drop3, inject, start_req;
  logic [255:0] ss_m;
  logic [2:0]   k_drv;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int ct_words_of(input logic [2:0] lvl);
    if (lvl == 3'd2) return 192;
    if (lvl == 3'd3) return 272;
    return 392;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    armed = 0; done_m = 0; ovf_m = 0; h1 = 0; h2 = 0; pipe1 = 0; pipe2 = 0;
    ct_rx = 0; ss_rx = 0; ctw = 0; ss_m = '0;
    core_ct_sent = 0; core_ss_sent = 0; req_seen = 0; req_total = 0;
    dut_pops = 0; last_idx = -1;
  endtask

  // One clock cycle: drive inputs at the falling edge, compare outputs 1 ns
  // later, then advance the core model and the expected-output model.
  task automatic step();
    bit cv, honored, phase_ct, phase_ss, exp_req, pop, acc_start, done_next;
    int inflight;
    @(negedge clk);
    ready_c = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    case (mr_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
    cv = 0;
    c_din = 32'd0;
    if (pipe2) begin
      cv = 1; c_din = $urandom; core_ct_sent++;
    end else if (armed && core_ct_sent == ctw && core_ss_sent < 8 && $urandom_range(0, 2) == 0) begin
      cv = 1; c_din = 32'hA5A5_0000 | 32'(core_ss_sent); core_ss_sent++;
    end
    if (inject) begin
      cv = 1; c_din = $urandom;
    end
    c_valid = cv;
    start   = start_req;
    k       = k_drv;
    #1;

    phase_ct = armed && ct_rx < ctw;
    phase_ss = armed && ct_rx == ctw && ss_rx < 8;
    inflight = int'(h1) + int'(h2);
    exp_req  = phase_ct && ready_c && (ct_rx + inflight < ctw) && (exp_q.size() + inflight < DEPTH);

    check("req_c", req_c, exp_req);
    check("m_valid", m_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("m_data", m_data, exp_q[0].d);
      check("m_last", m_last, exp_q[0].last);
    end
    check("ss_valid", ss_valid, armed && ss_rx == 8);
    check("done", done, done_m);
    check("overflow", overflow, ovf_m);
    if (armed && ss_rx == 8) check("ss", ss, ss_m);

    if (m_valid && m_ready) begin
      if (m_last) last_idx = dut_pops;
      dut_pops++;
    end
    if (req_c) req_total++;
    honored = req_c && !(drop3 && (req_seen % 3 == 2));
    if (req_c) req_seen++;
    pipe2 = pipe1;
    pipe1 = honored;

    done_next = done_m || (armed && ss_rx == 8 && exp_q.size() == 0);
    acc_start = start_req && (!armed || done_m);
    h2 = h1;
    h1 = exp_req;
    pop = (exp_q.size() != 0) && m_ready;
    if (pop) void'(exp_q.pop_front());
    if (acc_start) begin
      armed = 1; ctw = ct_words_of(k_drv); ct_rx = 0; ss_rx = 0; ss_m = '0;
      ovf_m = 0; done_next = 0; core_ct_sent = 0; core_ss_sent = 0;
      req_seen = 0; req_total = 0; dut_pops = 0; last_idx = -1;
    end
    if (cv) begin
      if (phase_ct) begin
        if (exp_q.size() == DEPTH) ovf_m = 1;
        else begin
          exp_q.push_back('{d: c_din, last: (ct_rx == ctw - 1)});
          ct_rx++;
        end
      end else if (phase_ss) begin
        ss_m = {c_din, ss_m[255:32]};
        ss_rx++;
      end else begin
        ovf_m = 1;
      end
    end
    done_m = done_next;
    if (exp_q.size() > DEPTH) check("fifo_bound", 32'(exp_q.size()), 32'(DEPTH));
  endtask

  task automatic run_txn(input logic [2:0] kv, input int exp_words, input bit rrand,
                         input int mr, input bit drop, input int hold, input bit kchange);
    bit kdone = 0;
    rdy_rand = rrand; drop3 = drop;
    mr_mode  = (hold > 0) ? 2 : mr;
    k_drv = kv; start_req = 1;
    step();
    start_req = 0;
    for (int cyc = 0; cyc < 6000 && !done_m; cyc++) begin
      if (hold > 0 && cyc == hold) begin
        check("hold_reqs", 32'(req_total), 32'd16);
        mr_mode = mr;
      end
      if (kchange && !kdone && ct_rx >= 50) begin
        k_drv = 3'd2; start_req = 1; kdone = 1;
      end else begin
        start_req = 0;
      end
      step();
    end
    start_req = 0;
    step();
    check("done_end", done, 1'b1);
    check("ss_valid_end", ss_valid, 1'b1);
    check("overflow_end", overflow, 1'b0);
    check("words_out", 32'(dut_pops), 32'(exp_words));
    check("last_index", 32'(last_idx), 32'(exp_words - 1));
    check("ss_literal", ss, SS_LIT);
  endtask

  initial begin
    rst = 1'b1; k = '0; start = 0; ready_c = 0; c_valid = 0; c_din = '0; m_ready = 0;
    k_drv = '0; start_req = 0; inject = 0; rdy_rand = 0; drop3 = 0; mr_mode = 0;
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_req_c", req_c, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ss_valid", ss_valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_ss", ss, 256'd0);
    @(negedge clk);
    rst = 1'b0;

    // k=2, full-rate core and host
    run_txn(3'd2, 192, 0, 0, 0, 0, 0);
    // k=3, host stalled long enough for the FIFO to fill, then released
    run_txn(3'd3, 272, 0, 1, 0, 80, 0);
    // k=4, core drops every third request, random ready_c/m_ready
    run_txn(3'd4, 392, 1, 1, 1, 0, 0);
    // k=4 latched, k changed to 2 and start pulsed mid-ciphertext
    run_txn(3'd4, 392, 1, 1, 0, 0, 1);
    // unlisted security level falls back to k=4 sizing
    run_txn(3'd7, 392, 1, 0, 0, 0, 0);

    // asynchronous reset after 100 ciphertext words
    rdy_rand = 1; drop3 = 0; mr_mode = 1; k_drv = 3'd4; start_req = 1;
    step();
    start_req = 0;
    for (int cyc = 0; cyc < 2000 && ct_rx < 100; cyc++) step();
    if (ct_rx < 100) check("t6_reach", 32'(ct_rx), 32'd100);
    #1 rst = 1'b1;
    #1;
    check("arst_m_valid", m_valid, 1'b0);
    check("arst_req_c", req_c, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_ss_valid", ss_valid, 1'b0);
    @(negedge clk);
    c_valid = 0; start = 0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    rdy_rand = 0; mr_mode = 0;
    repeat (4) step();

    // stray core word while idle
    inject = 1;
    step();
    inject = 0;
    repeat (3) step();
    check("idle_overflow", overflow, 1'b1);
    check("idle_fifo_empty", m_valid, 1'b0);
    run_txn(3'd2, 192, 1, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
